// File: rtl/mmio_responder.sv
// mmio_responder: answers CPU byte-bus accesses, decodes I/O space
// (a[17:16]==2'b11), and implements the UART TX/RX port, the cycle counter
// with a coherent 32-bit snapshot, and the program-stop port.
module mmio_responder #(
    parameter int TX_DEPTH    = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    input  logic [7:0]  ram_dout,
    output logic        io_buffer_full,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halt,
    output logic        tx_overflow
);

    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   cycle_cnt;
    logic [31:0]   snapshot;
    logic          rd_src;
    logic [7:0]    io_rdata;

    logic [7:0]    fifo_mem [TX_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          io_sel;
    logic [2:0]    off;
    logic          push_req;
    logic          push_ok;
    logic [7:0]    push_data;
    logic          tx_pop;
    logic          fifo_full;
    logic          unused_addr;

    assign io_sel      = (mem_a[17:16] == 2'b11);
    assign off         = mem_a[2:0];
    assign unused_addr = ^{mem_a[31:18], mem_a[15:3]};

    assign fifo_full      = (count == CW'(TX_DEPTH));
    assign tx_valid       = (count != '0);
    assign tx_data        = fifo_mem[rd_ptr];
    assign tx_pop         = tx_valid && tx_ready;
    assign io_buffer_full = ((CW'(TX_DEPTH) - count) <= CW'(FULL_MARGIN));
    assign push_ok        = rst_in && push_req && !fifo_full;
    assign mem_din        = rd_src ? io_rdata : ram_dout;

    // Decode CPU writes into a TX FIFO push request (data byte or terminator).
    always_comb begin
        push_req  = 1'b0;
        push_data = '0;
        if (rdy_in && io_sel && mem_wr && !halt) begin
            if (off == 3'd0 && mem_dout != 8'h00) begin
                push_req  = 1'b1;
                push_data = mem_dout;
            end else if (off == 3'd4) begin
                push_req  = 1'b1;
                push_data = 8'h00;
            end
        end
    end

    // TX FIFO storage; contents are discarded on reset via the pointers.
    always_ff @(posedge clk_in) begin
        if (push_ok)
            fifo_mem[wr_ptr] <= push_data;
    end

    // TX FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            tx_overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
            if (tx_pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push_ok && !tx_pop)
                count <= count + CW'(1);
            else if (!push_ok && tx_pop)
                count <= count - CW'(1);
            if (push_req && fifo_full)
                tx_overflow <= 1'b1;
        end
    end

    // CPU-side state: counter, snapshot, read-data register, RX pop and halt.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            cycle_cnt <= '0;
            snapshot  <= '0;
            rd_src    <= 1'b0;
            io_rdata  <= '0;
            halt      <= 1'b0;
            rx_ready  <= 1'b0;
        end else begin
            rx_ready <= 1'b0;
            if (rdy_in) begin
                cycle_cnt <= cycle_cnt + 32'd1;
                if (!mem_wr) begin
                    rd_src <= io_sel;
                    if (io_sel) begin
                        case (off)
                            3'd0: begin
                                if (rx_valid) begin
                                    io_rdata <= rx_data;
                                    rx_ready <= 1'b1;
                                end else begin
                                    io_rdata <= 8'h00;
                                end
                            end
                            3'd4: begin
                                snapshot <= cycle_cnt;
                                io_rdata <= cycle_cnt[7:0];
                            end
                            3'd5:    io_rdata <= snapshot[15:8];
                            3'd6:    io_rdata <= snapshot[23:16];
                            3'd7:    io_rdata <= snapshot[31:24];
                            default: io_rdata <= 8'h00;
                        endcase
                    end
                end else if (io_sel && !halt && off == 3'd4) begin
                    halt <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: directed scenarios plus a
// randomized run against a queue-based behavioural model.
module tb_mmio_responder;

    localparam int TX_DEPTH    = 8;
    localparam int FULL_MARGIN = 2;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic [31:0] mem_a = '0;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_dout = '0;
    logic [7:0]  mem_din;
    logic [7:0]  ram_dout = '0;
    logic        io_buffer_full;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        halt;
    logic        tx_overflow;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_cnt;
    logic [31:0] m_snap;
    logic [7:0]  m_q[$];
    logic        m_rd_src;
    logic [7:0]  m_io_rdata;
    logic        m_halt;
    logic        m_ovf;
    logic        m_rxr;
    logic [7:0]  got_tx[$];

    mmio_responder #(.TX_DEPTH(TX_DEPTH), .FULL_MARGIN(FULL_MARGIN)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din),
        .ram_dout(ram_dout), .io_buffer_full(io_buffer_full),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .halt(halt), .tx_overflow(tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    function automatic void model_update();
        logic       io;
        logic [2:0] off;
        logic       do_push;
        logic [7:0] pd;
        bit         was_full;
        if (!rst_in) begin
            m_cnt = '0; m_snap = '0; m_q.delete(); m_rd_src = 1'b0;
            m_io_rdata = '0; m_halt = 1'b0; m_ovf = 1'b0; m_rxr = 1'b0;
            return;
        end
        io = (mem_a[17:16] == 2'b11);
        off = mem_a[2:0];
        do_push = 1'b0;
        pd = '0;
        was_full = (m_q.size() == TX_DEPTH);
        if (m_q.size() != 0 && tx_ready) void'(m_q.pop_front());
        m_rxr = 1'b0;
        if (rdy_in) begin
            if (!mem_wr) begin
                m_rd_src = io;
                if (io) begin
                    case (off)
                        3'd0: begin
                            m_io_rdata = rx_valid ? rx_data : 8'h00;
                            m_rxr = rx_valid;
                        end
                        3'd4: begin
                            m_snap = m_cnt;
                            m_io_rdata = m_cnt[7:0];
                        end
                        3'd5: m_io_rdata = m_snap[15:8];
                        3'd6: m_io_rdata = m_snap[23:16];
                        3'd7: m_io_rdata = m_snap[31:24];
                        default: m_io_rdata = 8'h00;
                    endcase
                end
            end else if (io && !m_halt) begin
                if (off == 3'd0 && mem_dout != 8'h00) begin
                    do_push = 1'b1; pd = mem_dout;
                end else if (off == 3'd4) begin
                    m_halt = 1'b1; do_push = 1'b1; pd = 8'h00;
                end
            end
            m_cnt = m_cnt + 32'd1;
        end
        if (do_push) begin
            if (was_full) m_ovf = 1'b1;
            else m_q.push_back(pd);
        end
    endfunction

    // One clock: log any byte the UART takes, advance model, settle outputs.
    task automatic step();
        if (tx_valid && tx_ready) got_tx.push_back(tx_data);
        @(posedge clk_in);
        model_update();
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] d);
        mem_a = a; mem_wr = wr; mem_dout = d;
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        step(); step();
        rst_in = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        ram_dout = 8'h3C; rdy_in = 1'b1; tx_ready = 1'b0;
        drive(32'h0, 1'b0, 8'h00);
        rst_in = 1'b0;
        step(); step();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b exp 0", tx_valid); end
        checks++; if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL reset_buf_full got %b exp 0", io_buffer_full); end
        checks++; if (halt !== 1'b0 || tx_overflow !== 1'b0 || rx_ready !== 1'b0) begin
            errors++; $display("FAIL reset_flags got halt=%b ovf=%b rxr=%b exp 0", halt, tx_overflow, rx_ready); end
        checks++; if (mem_din !== 8'h3C) begin errors++; $display("FAIL reset_mem_din got %h exp 3c", mem_din); end
        rst_in = 1'b1;
        for (int i = 0; i < 10; i++) step();
        drive(32'h30004, 1'b0, 8'h00); step();
        v[7:0] = mem_din;
        drive(32'h30005, 1'b0, 8'h00); step();
        v[15:8] = mem_din;
        drive(32'h30006, 1'b0, 8'h00); step();
        v[23:16] = mem_din;
        drive(32'h30007, 1'b0, 8'h00); step();
        v[31:24] = mem_din;
        checks++; if (v !== 32'd10) begin errors++; $display("FAIL counter_snapshot got %h exp %h", v, 32'd10); end
        drive(32'h0, 1'b0, 8'h00);
    endtask

    task automatic test_uart_out();
        logic [7:0] seq [3];
        seq[0] = 8'h48; seq[1] = 8'h00; seq[2] = 8'h69;
        got_tx.delete();
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(32'h30000, 1'b1, seq[i]); step();
        end
        drive(32'h0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) step();
        checks++; if (got_tx.size() != 2) begin errors++; $display("FAIL uart_count got %0d exp 2", got_tx.size()); end
        else begin
            checks++; if (got_tx[0] !== 8'h48 || got_tx[1] !== 8'h69) begin
                errors++; $display("FAIL uart_bytes got %h %h exp 48 69", got_tx[0], got_tx[1]); end
        end
        checks++; if (tx_valid !== 1'b0 || tx_overflow !== 1'b0) begin
            errors++; $display("FAIL uart_idle got valid=%b ovf=%b exp 0 0", tx_valid, tx_overflow); end
    endtask

    task automatic test_backpressure();
        logic [7:0] sent [9];
        got_tx.delete();
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            sent[i] = 8'($urandom_range(1, 255));
            drive(32'h30000, 1'b1, sent[i]); step();
            if (i == 4) begin
                checks++; if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL bp_full_at5 got %b exp 0", io_buffer_full); end
            end
            if (i == 5) begin
                checks++; if (io_buffer_full !== 1'b1) begin errors++; $display("FAIL bp_full_at6 got %b exp 1", io_buffer_full); end
            end
            if (i == 7) begin
                checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL bp_ovf_at8 got %b exp 0", tx_overflow); end
            end
        end
        checks++; if (tx_overflow !== 1'b1) begin errors++; $display("FAIL bp_ovf_at9 got %b exp 1", tx_overflow); end
        drive(32'h0, 1'b0, 8'h00);
        tx_ready = 1'b1;
        for (int i = 0; i < 12; i++) step();
        checks++; if (got_tx.size() != 8) begin errors++; $display("FAIL bp_drain_count got %0d exp 8", got_tx.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                checks++; if (got_tx[i] !== sent[i]) begin
                    errors++; $display("FAIL bp_drain_byte%0d got %h exp %h", i, got_tx[i], sent[i]); end
            end
        end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", tx_valid); end
    endtask

    task automatic test_rx();
        rx_valid = 1'b1; rx_data = 8'h5A;
        drive(32'h30000, 1'b0, 8'h00); step();
        checks++; if (mem_din !== 8'h5A) begin errors++; $display("FAIL rx_data got %h exp 5a", mem_din); end
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rx_pulse got %b exp 1", rx_ready); end
        rx_valid = 1'b0;
        drive(32'h0, 1'b0, 8'h00); step();
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_pulse_end got %b exp 0", rx_ready); end
        drive(32'h30000, 1'b0, 8'h00); step();
        checks++; if (mem_din !== 8'h00 || rx_ready !== 1'b0) begin
            errors++; $display("FAIL rx_empty got din=%h rxr=%b exp 00 0", mem_din, rx_ready); end
        drive(32'h0, 1'b0, 8'h00); step();
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_empty_nopulse got %b exp 0", rx_ready); end
    endtask

    task automatic test_interleave();
        logic [31:0] c0;
        logic [31:0] c3;
        rdy_in = 1'b1; ram_dout = 8'hA5;
        c0 = m_cnt;
        drive(32'h30004, 1'b0, 8'h00); step();
        checks++; if (mem_din !== c0[7:0]) begin errors++; $display("FAIL il_cnt0 got %h exp %h", mem_din, c0[7:0]); end
        drive(32'h00100, 1'b0, 8'h00); step();
        checks++; if (mem_din !== 8'hA5) begin errors++; $display("FAIL il_ram got %h exp a5", mem_din); end
        drive(32'h30005, 1'b0, 8'h00); step();
        checks++; if (mem_din !== c0[15:8]) begin errors++; $display("FAIL il_snap1 got %h exp %h", mem_din, c0[15:8]); end
        rdy_in = 1'b0; ram_dout = 8'h11;
        drive(32'h00100, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (mem_din !== c0[15:8]) begin
                errors++; $display("FAIL il_frozen%0d got %h exp %h", i, mem_din, c0[15:8]); end
        end
        rdy_in = 1'b1;
        c3 = c0 + 32'd3;
        drive(32'h30004, 1'b0, 8'h00); step();
        checks++; if (mem_din !== c3[7:0]) begin errors++; $display("FAIL il_cnt_after got %h exp %h", mem_din, c3[7:0]); end
        drive(32'h0, 1'b0, 8'h00);
    endtask

    task automatic test_random();
        logic [7:0] exp_din;
        logic [2:0] off;
        for (int n = 0; n < 400; n++) begin
            rst_in   = ($urandom_range(0, 99) >= 2);
            rdy_in   = ($urandom_range(0, 3) != 0);
            mem_wr   = $urandom_range(0, 1) == 1;
            off      = 3'($urandom_range(0, 7));
            if (mem_wr && off == 3'd4) off = 3'd0;
            mem_a    = ($urandom_range(0, 2) != 0) ? {14'($urandom), 2'b11, 13'($urandom), off}
                                                   : {16'($urandom), 2'b00, 14'($urandom)};
            mem_dout = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            rx_valid = $urandom_range(0, 1) == 1;
            rx_data  = 8'($urandom);
            tx_ready = ($urandom_range(0, 2) == 0);
            ram_dout = 8'($urandom);
            step();
            exp_din = m_rd_src ? m_io_rdata : ram_dout;
            checks++; if (mem_din !== exp_din) begin errors++; $display("FAIL rnd_mem_din n=%0d got %h exp %h", n, mem_din, exp_din); end
            checks++; if (tx_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_tx_valid n=%0d got %b exp %b", n, tx_valid, m_q.size() != 0); end
            if (m_q.size() != 0) begin
                checks++; if (tx_data !== m_q[0]) begin errors++; $display("FAIL rnd_tx_data n=%0d got %h exp %h", n, tx_data, m_q[0]); end
            end
            checks++; if (io_buffer_full !== ((TX_DEPTH - m_q.size()) <= FULL_MARGIN)) begin
                errors++; $display("FAIL rnd_buf_full n=%0d got %b size %0d", n, io_buffer_full, m_q.size()); end
            checks++; if (tx_overflow !== m_ovf || rx_ready !== m_rxr || halt !== m_halt) begin
                errors++; $display("FAIL rnd_flags n=%0d got ovf=%b rxr=%b halt=%b exp %b %b %b",
                                   n, tx_overflow, rx_ready, halt, m_ovf, m_rxr, m_halt); end
        end
        rst_in = 1'b1; rdy_in = 1'b1; rx_valid = 1'b0;
        drive(32'h0, 1'b0, 8'h00);
    endtask

    task automatic test_stop();
        do_reset();
        got_tx.delete();
        tx_ready = 1'b1; rdy_in = 1'b1;
        drive(32'h30004, 1'b1, 8'h55); step();
        checks++; if (halt !== 1'b1) begin errors++; $display("FAIL stop_halt got %b exp 1", halt); end
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin
            errors++; $display("FAIL stop_term got valid=%b data=%h exp 1 00", tx_valid, tx_data); end
        drive(32'h30000, 1'b1, 8'h41); step();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL stop_nopush got %b exp 0", tx_valid); end
        drive(32'h0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) step();
        checks++; if (got_tx.size() != 1 || got_tx[0] !== 8'h00) begin
            errors++; $display("FAIL stop_tx_seq got %0d bytes exp 1 byte 00", got_tx.size()); end
        rst_in = 1'b0; step();
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL stop_reset got %b exp 0", halt); end
        rst_in = 1'b1;
    endtask

    initial begin
        #1;
        test_reset();
        test_uart_out();
        test_backpressure();
        do_reset();
        test_rx();
        test_interleave();
        test_random();
        test_stop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_responder.md
Name: mmio_responder

Overview:
Memory-side responder for the CPU byte bus (mem_a/mem_dout/mem_wr/mem_din). It answers every CPU access, decodes I/O space (a[17:16]==2'b11) and implements the UART TX/RX port, the cycle counter and the program-stop port. It muxes registered I/O read data with the RAM's data. It sits between the CPU top, the RAM and the UART.

Parameters:
TX_DEPTH, 8, TX FIFO entries; power of two, >=4
FULL_MARGIN, 2, io_buffer_full asserts when free entries <= FULL_MARGIN

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, synchronous, active-low
rdy_in  input  1  CPU-side enable; low freezes all CPU-side state
mem_a  input  32  CPU address; only [17:0] decoded
mem_wr  input  1  1 = write, 0 = read
mem_dout  input  8  CPU write data
mem_din  output  8  read data to CPU, valid the cycle after the request
ram_dout  input  8  RAM read data, already one cycle late
io_buffer_full  output  1  TX FIFO nearly full
rx_data  input  8  UART received byte
rx_valid  input  1  rx_data holds an unread byte
rx_ready  output  1  one-cycle pop pulse to the UART RX
tx_data  output  8  byte to the UART TX
tx_valid  output  1  TX FIFO non-empty
tx_ready  input  1  UART accepts tx_data this cycle
halt  output  1  sticky; program wrote 0x30004
tx_overflow  output  1  sticky; a byte was dropped because the TX FIFO was full

Behaviour:
- Reset (rst_in==0 at posedge): cycle counter=0, snapshot=0, TX FIFO empty, rd_src=RAM, io_rdata=0, halt=0, tx_overflow=0, rx_ready=0. Outputs: tx_valid=0, io_buffer_full=0, mem_din=ram_dout. Reset wins over every other event.
- Decode: io = (mem_a[17:16]==2'b11); off = mem_a[2:0]. Non-I/O accesses affect only rd_src.
- Read path:
  - On a rdy_in-high cycle with mem_wr==0, register rd_src=io and io_rdata.
  - mem_din = rd_src ? io_rdata : ram_dout (combinational), giving 1-cycle read latency.
  - Writes leave rd_src and io_rdata unchanged.
- rdy_in low:
  - No counter increment, no RX pop, no FIFO push, no snapshot, no rd_src/io_rdata update.
  - TX drain to the UART continues independently.
- Cycle counter: 32-bit, +1 each rdy_in-high cycle out of reset; wraps 0xFFFFFFFF->0.
- Read off 0: if rx_valid, io_rdata=rx_data and rx_ready=1 for exactly the next cycle. Otherwise io_rdata=0x00 and no pop.
- Read off 4: snapshot<=counter, io_rdata=counter[7:0] (same value).
- Read off 5/6/7: io_rdata = snapshot[15:8]/[23:16]/[31:24]. The snapshot is unchanged, so a 4-byte read is coherent.
- Read other I/O offsets: io_rdata=0x00.
- Write off 0, data!=0, halt==0: push mem_dout. Data 0x00 is ignored.
- Write off 4, halt==0: set halt and push 0x00 (terminator).
- All I/O writes are ignored once halt==1. Writes to other offsets are ignored.
- Push into a full FIFO: byte dropped, tx_overflow<=1, pointers unchanged.
- TX FIFO: circular, wr/rd pointers with wrap at TX_DEPTH, count 0..TX_DEPTH.
  - tx_valid = count!=0; tx_data = entry at rd pointer.
  - Pop on tx_valid&&tx_ready.
  - Simultaneous push and pop at a non-empty FIFO: count unchanged, both pointers advance.
  - Push at empty with tx_ready high: the byte appears on tx_data the next cycle. No same-cycle bypass.
- io_buffer_full = (TX_DEPTH - count) <= FULL_MARGIN, from registered count. The CPU may issue up to FULL_MARGIN writes after observing it.
- Reset mid-transfer: FIFO contents are discarded, and an rx_ready pulse in flight is cancelled.

Test Plan:
- Reset: rst_in=0 for 2 cycles, then release with rdy_in=1 for 10 cycles, then read 0x30004..0x30007 -> mem_din one cycle after each read = counter at the 0x30004 read, LSB first, and the 4 bytes form one consistent 32-bit value despite increments during the sequence.
- UART out: write 0x48, 0x00, 0x69 to 0x30000 with tx_ready=1 -> tx_data sequence 0x48, 0x69 only; tx_valid low afterwards; no overflow.
- Backpressure: tx_ready=0, write 6 non-zero bytes with TX_DEPTH=8 -> io_buffer_full rises after the 6th push (count=6). Then write 3 more -> the 9th is dropped and tx_overflow=1. Set tx_ready=1 -> exactly 8 bytes drain in order.
- RX: rx_valid=1, rx_data=0x5A, read 0x30000 -> mem_din=0x5A next cycle, rx_ready single pulse. Repeat with rx_valid=0 -> mem_din=0x00, no pulse.
- Interleave: read RAM address 0x00100 (ram_dout=0xA5) then I/O 0x30005 -> mem_din 0xA5 then snapshot[15:8]. Hold rdy_in=0 for 3 cycles mid-sequence -> counter, rd_src and mem_din frozen.
- Stop: write 0x30004 -> halt=1, 0x00 emitted on tx. Subsequent write 0x41 to 0x30000 -> no push. Reset -> halt=0.
